// File: rtl/spi_flash_responder.sv
// Memory-bus responder that serves the parallel flash slot from an SPI NOR flash (mode 0).
// Optional `BUSY_POLL_EN: poll the status register after a page program until WIP clears.
module spi_flash_responder #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned CLK_DIV  = 2,
  parameter logic [7:0]  READ_CMD = 8'h03,
  parameter logic [7:0]  PROG_CMD = 8'h02,
  parameter logic [7:0]  WREN_CMD = 8'h06
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              oe_,
  input  logic              we_,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic              data_oe,
  output logic              ready,
  output logic              spi_sclk,
  output logic              spi_cs_,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int unsigned CNT_W   = $clog2(2 * CLK_DIV) + 1;
  localparam int unsigned BIT_W   = 6;
  localparam int unsigned FRAME_W = 40;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(2 * CLK_DIV - 1);
`ifdef BUSY_POLL_EN
  localparam logic [7:0] STATUS_CMD = 8'h05;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_WREN, S_GAP, S_CMD, S_ADDR, S_DATA, S_DONE, S_PGAP, S_STATUS
  } state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_oe_d1, r_oe_d2, r_we_d1, r_we_d2;
  logic                 r_cs, w_cs_nxt;
  logic                 r_sclk, w_sclk_nxt;
  logic                 r_mosi, w_mosi_nxt;
  logic                 r_ready, w_ready_nxt;
  logic [7:0]           r_data_out, w_data_out_nxt;
  logic                 r_data_oe, w_data_oe_nxt;
  logic [CNT_W-1:0]     r_div, w_div_nxt;
  logic [CNT_W-1:0]     r_gap, w_gap_nxt;
  logic [BIT_W-1:0]     r_bit, w_bit_nxt;
  logic [FRAME_W-2:0]   r_sh_out, w_sh_out_nxt;
  logic [7:0]           r_sh_in, w_sh_in_nxt;
  logic [23:0]          r_addr, w_addr_nxt;
  logic [7:0]           r_wdata, w_wdata_nxt;
  logic                 r_is_read, w_is_read_nxt;
  logic                 r_released, w_released_nxt;

  logic                 w_oe_fall, w_we_fall;
  logic                 w_in_frame, w_sample, w_end, w_start;
  logic [BIT_W-1:0]     w_bit_last;
  logic [7:0]           w_in_shift, w_in_final;
  logic [FRAME_W-1:0]   w_word;

  assign w_oe_fall  = r_oe_d2 & ~r_oe_d1;
  assign w_we_fall  = r_we_d2 & ~r_we_d1;
  assign w_in_frame = (r_state == S_WREN) || (r_state == S_CMD) || (r_state == S_ADDR) ||
                      (r_state == S_DATA) || (r_state == S_STATUS);
`ifdef BUSY_POLL_EN
  assign w_bit_last = (r_state == S_WREN)   ? BIT_W'(7)  :
                      (r_state == S_STATUS) ? BIT_W'(15) : BIT_W'(39);
`else
  assign w_bit_last = (r_state == S_WREN) ? BIT_W'(7) : BIT_W'(39);
`endif
  // MISO is captured in the first cycle of each SCLK-high phase.
  assign w_sample   = w_in_frame & r_sclk & (r_div == '0);
  assign w_in_shift = {r_sh_in[6:0], spi_miso};
  assign w_in_final = w_sample ? w_in_shift : r_sh_in;

  always_comb begin
    w_state_nxt    = r_state;
    w_cs_nxt       = r_cs;
    w_sclk_nxt     = r_sclk;
    w_mosi_nxt     = r_mosi;
    w_ready_nxt    = r_ready;
    w_data_out_nxt = r_data_out;
    w_data_oe_nxt  = r_data_oe;
    w_div_nxt      = r_div;
    w_gap_nxt      = r_gap;
    w_bit_nxt      = r_bit;
    w_sh_out_nxt   = r_sh_out;
    w_sh_in_nxt    = r_sh_in;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_is_read_nxt  = r_is_read;
    w_released_nxt = r_released;
    w_end          = 1'b0;
    w_start        = 1'b0;
    w_word         = '0;

    if (w_sample) w_sh_in_nxt = w_in_shift;
    if (r_is_read && !r_ready && oe_) w_released_nxt = 1'b1;

    // Bit engine: D cycles low, D cycles high, next bit presented on the falling edge.
    if (w_in_frame) begin
      if (r_div == DIV_LAST) begin
        w_div_nxt  = '0;
        w_sclk_nxt = ~r_sclk;
        if (r_sclk) begin
          if (r_bit == w_bit_last) begin
            w_end = 1'b1;
          end else begin
            w_bit_nxt    = r_bit + BIT_W'(1);
            w_mosi_nxt   = r_sh_out[FRAME_W-2];
            w_sh_out_nxt = {r_sh_out[FRAME_W-3:0], 1'b0};
            if (r_state == S_CMD  && r_bit == BIT_W'(7))  w_state_nxt = S_ADDR;
            if (r_state == S_ADDR && r_bit == BIT_W'(31)) w_state_nxt = S_DATA;
          end
        end
      end else begin
        w_div_nxt = r_div + CNT_W'(1);
      end
    end

    case (r_state)
      S_IDLE, S_DONE: begin
        w_state_nxt   = S_IDLE;
        w_data_oe_nxt = r_data_oe & ~oe_;
        if (w_oe_fall && !w_we_fall) begin
          w_state_nxt    = S_CMD;
          w_ready_nxt    = 1'b0;
          w_data_oe_nxt  = 1'b0;
          w_is_read_nxt  = 1'b1;
          w_released_nxt = 1'b0;
          w_start        = 1'b1;
          w_word         = {READ_CMD, 24'(addr), 8'h00};
        end else if (w_we_fall && !w_oe_fall) begin
          w_state_nxt   = S_WREN;
          w_ready_nxt   = 1'b0;
          w_data_oe_nxt = 1'b0;
          w_is_read_nxt = 1'b0;
          w_addr_nxt    = 24'(addr);
          w_wdata_nxt   = data_in;
          w_start       = 1'b1;
          w_word        = {WREN_CMD, 32'h0};
        end
      end
      S_WREN: begin
        if (w_end) begin
          w_cs_nxt    = 1'b1;
          w_mosi_nxt  = 1'b0;
          w_gap_nxt   = '0;
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (r_gap == GAP_LAST) begin
          w_state_nxt = S_CMD;
          w_start     = 1'b1;
          w_word      = {PROG_CMD, r_addr, r_wdata};
        end else begin
          w_gap_nxt = r_gap + CNT_W'(1);
        end
      end
      S_CMD, S_ADDR: ;
      S_DATA: begin
        if (w_end) begin
          w_cs_nxt   = 1'b1;
          w_mosi_nxt = 1'b0;
          if (r_is_read) begin
            w_ready_nxt    = 1'b1;
            w_data_out_nxt = w_in_final;
            w_data_oe_nxt  = ~oe_ & ~r_released;
            w_state_nxt    = S_DONE;
          end else begin
`ifdef BUSY_POLL_EN
            w_gap_nxt   = '0;
            w_state_nxt = S_PGAP;
`else
            w_ready_nxt = 1'b1;
            w_state_nxt = S_DONE;
`endif
          end
        end
      end
`ifdef BUSY_POLL_EN
      S_PGAP: begin
        if (r_gap == GAP_LAST) begin
          w_state_nxt = S_STATUS;
          w_start     = 1'b1;
          w_word      = {STATUS_CMD, 32'h0};
        end else begin
          w_gap_nxt = r_gap + CNT_W'(1);
        end
      end
      S_STATUS: begin
        if (w_end) begin
          w_cs_nxt   = 1'b1;
          w_mosi_nxt = 1'b0;
          if (w_in_final[0]) begin
            w_gap_nxt   = '0;
            w_state_nxt = S_PGAP;
          end else begin
            w_ready_nxt = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_start) begin
      w_cs_nxt     = 1'b0;
      w_sclk_nxt   = 1'b0;
      w_div_nxt    = '0;
      w_bit_nxt    = '0;
      w_mosi_nxt   = w_word[FRAME_W-1];
      w_sh_out_nxt = w_word[FRAME_W-2:0];
      w_sh_in_nxt  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state    <= S_IDLE;
      r_oe_d1    <= 1'b1;
      r_oe_d2    <= 1'b1;
      r_we_d1    <= 1'b1;
      r_we_d2    <= 1'b1;
      r_cs       <= 1'b1;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_ready    <= 1'b1;
      r_data_out <= 8'h00;
      r_data_oe  <= 1'b0;
      r_div      <= '0;
      r_gap      <= '0;
      r_bit      <= '0;
      r_sh_out   <= '0;
      r_sh_in    <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_is_read  <= 1'b0;
      r_released <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_oe_d1    <= oe_;
      r_oe_d2    <= r_oe_d1;
      r_we_d1    <= we_;
      r_we_d2    <= r_we_d1;
      r_cs       <= w_cs_nxt;
      r_sclk     <= w_sclk_nxt;
      r_mosi     <= w_mosi_nxt;
      r_ready    <= w_ready_nxt;
      r_data_out <= w_data_out_nxt;
      r_data_oe  <= w_data_oe_nxt;
      r_div      <= w_div_nxt;
      r_gap      <= w_gap_nxt;
      r_bit      <= w_bit_nxt;
      r_sh_out   <= w_sh_out_nxt;
      r_sh_in    <= w_sh_in_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_is_read  <= w_is_read_nxt;
      r_released <= w_released_nxt;
    end
  end

  assign spi_cs_  = r_cs;
  assign spi_sclk = r_sclk;
  assign spi_mosi = r_mosi;
  assign ready    = r_ready;
  assign data_out = r_data_out;
  assign data_oe  = r_data_oe;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Randomized bench for spi_flash_responder with an SPI flash model and frame-level reference.
module tb_spi_flash_responder;

  localparam int D = 2;

  logic        clk = 1'b0;
  logic        rst_ = 1'b0;
  logic        oe_ = 1'b1;
  logic        we_ = 1'b1;
  logic [15:0] addr = 16'h0;
  logic [7:0]  data_in = 8'h0;
  logic [7:0]  data_out;
  logic        data_oe, ready, spi_sclk, spi_cs_, spi_mosi;
  logic        spi_miso = 1'b0;

  spi_flash_responder #(.ADDR_W(16), .CLK_DIV(D)) dut (
    .clk(clk), .rst_(rst_), .oe_(oe_), .we_(we_), .addr(addr), .data_in(data_in),
    .data_out(data_out), .data_oe(data_oe), .ready(ready), .spi_sclk(spi_sclk),
    .spi_cs_(spi_cs_), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // flash model and frame recorder
  logic        prev_cs = 1'b1;
  logic        prev_sclk = 1'b0;
  int          fc = 0;
  logic [39:0] f_bits [512];
  int          f_nb [512];
  int          f_start [512];
  int          f_end [512];
  bit          f_tok [512];
  logic [39:0] cur_bits;
  int          cur_nb, cur_start;
  bit          cur_tok;
  logic [7:0]  cur_op, cur_resp;
  logic [7:0]  rd_resp = 8'h00;
  logic [7:0]  st_q [$];
  int          stray = 0;
  int          busy_oe_bad = 0;
`ifdef BUSY_POLL_EN
  int          poll_n = 1;
`endif

  always @(negedge clk) begin
    if (!spi_cs_ && prev_cs) begin
      cur_start = cyc; cur_nb = 0; cur_bits = '0; cur_tok = !spi_sclk;
      cur_op = 8'h00; cur_resp = rd_resp;
    end
    if (!spi_cs_) begin
      if (spi_sclk && !prev_sclk) begin
        if (cyc - cur_start != D + 2 * D * cur_nb) cur_tok = 1'b0;
        cur_bits = {cur_bits[38:0], spi_mosi};
        cur_nb++;
        if (cur_nb == 8) begin
          cur_op = cur_bits[7:0];
          if (cur_op == 8'h05) cur_resp = (st_q.size() > 0) ? st_q.pop_front() : 8'h00;
        end
      end
      if (!spi_sclk && prev_sclk) begin
        if (cur_op == 8'h05 && cur_nb >= 8 && cur_nb < 16) spi_miso = cur_resp[15 - cur_nb];
        else if (cur_op == 8'h03 && cur_nb >= 32 && cur_nb < 40) spi_miso = cur_resp[39 - cur_nb];
        else spi_miso = 1'($urandom);
      end
    end
    if (spi_cs_ && !prev_cs && fc < 512) begin
      f_bits[fc] = cur_bits; f_nb[fc] = cur_nb; f_start[fc] = cur_start;
      f_end[fc] = cyc; f_tok[fc] = cur_tok; fc++;
    end
    if (spi_cs_ && spi_sclk) stray++;
    if (!ready && data_oe) busy_oe_bad++;
    prev_cs = spi_cs_;
    prev_sclk = spi_sclk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input logic lvl, input int budget, output int at, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (ready === lvl) begin ok = 1'b1; break; end
      tick();
    end
    at = cyc;
  endtask

  task automatic do_read(input logic [15:0] a, input logic [7:0] resp, input bit rel);
    int f0, t0, n1, r;
    bit ok;
    rd_resp = resp; addr = a; f0 = fc; t0 = cyc;
    oe_ = 1'b0;
    wait_ready(1'b0, 8, n1, ok);
    check("rd_start", 64'(ok), 1);
    check("rd_latency_le3", 64'((n1 - t0) <= 3), 1);
    check("rd_cs_fall_with_ready", 64'(spi_cs_), 0);
    wait_ready(1'b1, 80 * D + 20, r, ok);
    check("rd_done", 64'(ok), 1);
    check("rd_ready_cycles", 64'(r - n1), 64'(80 * D));
    check("rd_data_out", 64'(data_out), 64'(resp));
    check("rd_data_oe_on", 64'(data_oe), 1);
    check("rd_nframes", 64'(fc - f0), 1);
    check("rd_mosi", 64'(f_bits[f0][39:8]), 64'({8'h03, 8'h00, a}));
    check("rd_nbits", 64'(f_nb[f0]), 40);
    check("rd_cs_start", 64'(f_start[f0]), 64'(n1));
    check("rd_cs_end", 64'(f_end[f0]), 64'(n1 + 80 * D));
    check("rd_bit_timing", 64'(f_tok[f0]), 1);
    repeat (3) tick();
    check("rd_data_oe_hold", 64'(data_oe), 1);
    if (rel) begin
      oe_ = 1'b1;
      tick();
      check("rd_data_oe_off", 64'(data_oe), 0);
    end
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d);
    int f0, n1, r, nst, st;
    bit ok;
    nst = 0;
`ifdef BUSY_POLL_EN
    nst = poll_n;
    st_q.delete();
    for (int k = 0; k < poll_n; k++) st_q.push_back({7'($urandom), (k != poll_n - 1)});
`endif
    addr = a; data_in = d; f0 = fc;
    we_ = 1'b0;
    wait_ready(1'b0, 8, n1, ok);
    check("wr_start", 64'(ok), 1);
    wait_ready(1'b1, 200 * D + 40 * D * nst, r, ok);
    check("wr_done", 64'(ok), 1);
    check("wr_ready_cycles", 64'(r - n1), 64'(98 * D + 34 * D * nst));
    check("wr_data_oe", 64'(data_oe), 0);
    check("wr_nframes", 64'(fc - f0), 64'(2 + nst));
    check("wren_bits", 64'({f_nb[f0][7:0], f_bits[f0][7:0]}), 64'({8'd8, 8'h06}));
    check("wren_span", 64'({f_start[f0] - n1, f_end[f0] - n1}), 64'({32'd0, 32'(16 * D)}));
    check("prog_bits", 64'(f_bits[f0 + 1]), 64'({8'h02, 8'h00, a, d}));
    check("prog_nbits", 64'(f_nb[f0 + 1]), 40);
    check("prog_span", 64'({f_start[f0 + 1] - n1, f_end[f0 + 1] - n1}),
          64'({32'(18 * D), 32'(98 * D)}));
    check("wr_bit_timing", 64'(f_tok[f0] & f_tok[f0 + 1]), 1);
    st = n1 + 98 * D;
    for (int k = 0; k < nst; k++) begin
      check("stat_frame", 64'({f_nb[f0 + 2 + k][7:0], f_bits[f0 + 2 + k][15:8]}),
            64'({8'd16, 8'h05}));
      check("stat_span", 64'({f_start[f0 + 2 + k], f_end[f0 + 2 + k]}),
            64'({32'(st + 2 * D), 32'(st + 34 * D)}));
      st = st + 34 * D;
    end
    we_ = 1'b1;
    tick();
  endtask

  initial begin
    int f0, n1, r, lows, s0;
    bit ok;
    logic [7:0] resp;

    repeat (2) tick();
    check("rst_cs", 64'(spi_cs_), 1);
    check("rst_sclk", 64'(spi_sclk), 0);
    check("rst_mosi", 64'(spi_mosi), 0);
    check("rst_ready", 64'(ready), 1);
    check("rst_data_out", 64'(data_out), 0);
    check("rst_data_oe", 64'(data_oe), 0);
    rst_ = 1'b1;
    repeat (3) tick();

    do_read(16'h1234, 8'hA5, 1'b1);
`ifdef BUSY_POLL_EN
    poll_n = 3;
`endif
    do_write(16'hBEEF, 8'h5C);

    // both strobes fall together: ignored
    f0 = fc; lows = 0;
    oe_ = 1'b0; we_ = 1'b0;
    repeat (12) begin tick(); if (!ready) lows++; end
    check("simul_ready_low", 64'(lows), 0);
    check("simul_nframes", 64'(fc - f0), 0);
    oe_ = 1'b1; we_ = 1'b1;
    repeat (3) tick();

    // second oe_ edge while busy, strobe released mid-frame
    f0 = fc; rd_resp = 8'h3C; addr = 16'h0F0F;
    oe_ = 1'b0;
    wait_ready(1'b0, 8, n1, ok);
    repeat (20) tick();
    oe_ = 1'b1;
    repeat (3) tick();
    oe_ = 1'b0;
    wait_ready(1'b1, 80 * D + 20, r, ok);
    check("busy_done", 64'(ok), 1);
    check("busy_data_out", 64'(data_out), 8'h3C);
    check("busy_data_oe", 64'(data_oe), 0);
    repeat (10) tick();
    check("busy_nframes", 64'(fc - f0), 1);
    check("busy_no_oe_later", 64'(data_oe), 0);
    oe_ = 1'b1;
    repeat (3) tick();

    // back-to-back: held strobe starts nothing, a fresh edge starts a frame promptly
    do_read(16'h00FF, 8'h96, 1'b0);
    f0 = fc;
    repeat (10) tick();
    check("b2b_no_frame", 64'(fc - f0), 0);
    check("b2b_oe_held", 64'(data_oe), 1);
    oe_ = 1'b1;
    tick();
    check("b2b_oe_drop", 64'(data_oe), 0);
    do_read(16'h8001, 8'h69, 1'b1);

    // asynchronous reset in the middle of a read frame
    addr = 16'h4242; rd_resp = 8'hFF;
    oe_ = 1'b0;
    wait_ready(1'b0, 8, n1, ok);
    repeat (30) tick();
    #2 rst_ = 1'b0;
    #1;
    check("arst_cs", 64'(spi_cs_), 1);
    check("arst_sclk", 64'(spi_sclk), 0);
    check("arst_ready", 64'(ready), 1);
    check("arst_data_oe", 64'(data_oe), 0);
    s0 = stray; f0 = fc;
    oe_ = 1'b1;
    repeat (6) tick();
    rst_ = 1'b1;
    repeat (6) tick();
    check("arst_no_sclk", 64'(stray - s0), 0);
    check("arst_no_new_frame", 64'(fc - f0), 1);

    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        resp = 8'($urandom);
        do_read(16'($urandom), resp, 1'b1);
      end else begin
`ifdef BUSY_POLL_EN
        poll_n = $urandom_range(1, 3);
`endif
        do_write(16'($urandom), 8'($urandom));
      end
      repeat ($urandom_range(1, 5)) tick();
    end

    check("stray_sclk", 64'(stray - s0), 0);
    check("data_oe_while_busy", 64'(busy_oe_bad), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
